// File: rtl/cache_victim_select_pkg.sv
// Shared cache geometry and PLRU tree node indexing for the 8-way victim selector.
package cache_victim_select_pkg;
  localparam int WAYS   = 8;
  localparam int WAY_W  = 3;
  localparam int SETS   = 16;
  localparam int SET_W  = 4;
  localparam int PLRU_W = 7;

  // Heap-ordered tree: level-1 node under the root for the chosen half
  function automatic logic [2:0] plru_node_l1(input logic w2);
    return 3'd1 + {2'b00, w2};
  endfunction

  // Leaf-level node selected by the two upper way bits
  function automatic logic [2:0] plru_node_l2(input logic [1:0] w21);
    return 3'd3 + {1'b0, w21};
  endfunction
endpackage

// File: rtl/cache_victim_select_plru8_logic.sv
// Combinational 8-way tree-PLRU: victim pick (invalid ways first) and touch update.
module plru8_logic
  import cache_victim_select_pkg::*;
(
  input  logic [PLRU_W-1:0] plru,
  input  logic [WAYS-1:0]   valid,
  input  logic [WAY_W-1:0]  touch_way,
  output logic [WAY_W-1:0]  victim_way,
  output logic [PLRU_W-1:0] plru_next
);

  logic w2, w1, w0;

  always_comb begin
    w2 = plru[0];
    w1 = plru[plru_node_l1(w2)];
    w0 = plru[plru_node_l2({w2, w1})];
    victim_way = {w2, w1, w0};
    if (valid != '1) begin
      // Descending scan so the lowest invalid index wins
      victim_way = '0;
      for (int i = WAYS - 1; i >= 0; i--) begin
        if (!valid[i]) victim_way = WAY_W'(i);
      end
    end
  end

  always_comb begin
    plru_next = plru;
    plru_next[0] = ~touch_way[2];
    plru_next[plru_node_l1(touch_way[2])] = ~touch_way[1];
    plru_next[plru_node_l2(touch_way[2:1])] = ~touch_way[0];
  end

endmodule

// File: rtl/cache_victim_select.sv
// Per-set replacement-way picker: holds PLRU/valid state per set and a one-entry victim buffer.
module cache_victim_select
  import cache_victim_select_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lookup_valid,
  input  logic [SET_W-1:0] lookup_set,
  output logic             lookup_ready,
  output logic             victim_valid,
  output logic [SET_W-1:0] victim_set,
  output logic [WAY_W-1:0] victim_way,
  input  logic             victim_ready,
  input  logic             touch_valid,
  input  logic [SET_W-1:0] touch_set,
  input  logic [WAY_W-1:0] touch_way,
  input  logic             inval_valid,
  input  logic [SET_W-1:0] inval_set,
  input  logic [WAY_W-1:0] inval_way
);

  logic [PLRU_W-1:0] plru_q  [SETS];
  logic [WAYS-1:0]   valid_q [SETS];

  logic [WAY_W-1:0]  pick_way;
  logic [PLRU_W-1:0] pick_plru_unused;
  logic [WAY_W-1:0]  touch_victim_unused;
  logic [PLRU_W-1:0] touch_plru_next;
  logic              accept;

  assign lookup_ready = !victim_valid || victim_ready;
  assign accept       = lookup_valid && lookup_ready;

  plru8_logic u_pick (
    .plru       (plru_q[lookup_set]),
    .valid      (valid_q[lookup_set]),
    .touch_way  (touch_way),
    .victim_way (pick_way),
    .plru_next  (pick_plru_unused)
  );

  plru8_logic u_touch (
    .plru       (plru_q[touch_set]),
    .valid      (valid_q[touch_set]),
    .touch_way  (touch_way),
    .victim_way (touch_victim_unused),
    .plru_next  (touch_plru_next)
  );

  // Output buffer stage: one pending victim, held until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      victim_valid <= 1'b0;
      victim_set   <= '0;
      victim_way   <= '0;
    end else if (accept) begin
      victim_valid <= 1'b1;
      victim_set   <= lookup_set;
      victim_way   <= pick_way;
    end else if (victim_ready) begin
      victim_valid <= 1'b0;
    end
  end

  // Inval is written after touch so a same-way collision leaves the way invalid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        plru_q[s]  <= '0;
        valid_q[s] <= '0;
      end
    end else begin
      if (touch_valid) begin
        plru_q[touch_set]             <= touch_plru_next;
        valid_q[touch_set][touch_way] <= 1'b1;
      end
      if (inval_valid) begin
        valid_q[inval_set][inval_way] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cache_victim_select.sv
// Scoreboard bench for cache_victim_select: directed lookups/touches with hand-computed victims.
module tb_cache_victim_select;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       lookup_valid;
  logic [3:0] lookup_set;
  logic       lookup_ready;
  logic       victim_valid;
  logic [3:0] victim_set;
  logic [2:0] victim_way;
  logic       victim_ready;
  logic       touch_valid;
  logic [3:0] touch_set;
  logic [2:0] touch_way;
  logic       inval_valid;
  logic [3:0] inval_set;
  logic [2:0] inval_way;

  int errors = 0;
  int checks = 0;
  logic [6:0] exp_q[$];

  cache_victim_select dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lookup_valid (lookup_valid),
    .lookup_set   (lookup_set),
    .lookup_ready (lookup_ready),
    .victim_valid (victim_valid),
    .victim_set   (victim_set),
    .victim_way   (victim_way),
    .victim_ready (victim_ready),
    .touch_valid  (touch_valid),
    .touch_set    (touch_set),
    .touch_way    (touch_way),
    .inval_valid  (inval_valid),
    .inval_set    (inval_set),
    .inval_way    (inval_way)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: a victim is consumed at the next edge whenever valid&&ready at the falling edge
  always @(negedge clk) begin
    if (rst_n && victim_valid && victim_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_victim", 1, 0);
      end else begin
        logic [6:0] e;
        logic [7:0] sel;
        e = exp_q.pop_front();
        sel = 8'h01 << victim_way;
        check("victim_set", int'(victim_set), int'(e[6:3]));
        check("victim_way", int'(victim_way), int'(e[2:0]));
        check("encoder_sel", int'(sel), int'(8'h01 << e[2:0]));
      end
    end
  end

  task automatic lookup(input logic [3:0] s, input logic [2:0] w);
    bit ok;
    ok = 1'b0;
    lookup_valid = 1'b1;
    lookup_set   = s;
    exp_q.push_back({s, w});
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = lookup_ready;
      @(posedge clk);
      #1;
    end
    lookup_valid = 1'b0;
    if (!ok) check("lookup_accept_timeout", 0, 1);
  endtask

  task automatic touch(input logic [3:0] s, input logic [2:0] w);
    touch_valid = 1'b1;
    touch_set   = s;
    touch_way   = w;
    @(posedge clk);
    #1;
    touch_valid = 1'b0;
  endtask

  task automatic inval(input logic [3:0] s, input logic [2:0] w);
    inval_valid = 1'b1;
    inval_set   = s;
    inval_way   = w;
    @(posedge clk);
    #1;
    inval_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    lookup_valid = 1'b0; lookup_set = '0; victim_ready = 1'b1;
    touch_valid = 1'b0; touch_set = '0; touch_way = '0;
    inval_valid = 1'b0; inval_set = '0; inval_way = '0;
    idle(3);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_victim_valid", int'(victim_valid), 0);
    check("rst_victim_set", int'(victim_set), 0);
    check("rst_victim_way", int'(victim_way), 0);
    check("rst_lookup_ready", int'(lookup_ready), 1);
    @(posedge clk); #1;

    // 1: empty set -> way 0, visible one cycle after acceptance
    lookup(4'd3, 3'd0);
    check("lat1_victim_valid", int'(victim_valid), 1);
    idle(2);

    // 2: fill all ways in order -> tree all zero -> way 0
    for (int w = 0; w < 8; w++) touch(4'd3, 3'(w));
    lookup(4'd3, 3'd0);
    idle(1);

    // 3: PLRU walk after touches
    touch(4'd3, 3'd0);
    lookup(4'd3, 3'd4);
    touch(4'd3, 3'd4);
    lookup(4'd3, 3'd2);
    idle(1);

    // 4: invalidation, then touch+inval collision on the same way
    inval(4'd3, 3'd6);
    lookup(4'd3, 3'd6);
    touch_valid = 1'b1; touch_set = 4'd3; touch_way = 3'd6;
    inval_valid = 1'b1; inval_set = 4'd3; inval_way = 3'd6;
    @(posedge clk); #1;
    touch_valid = 1'b0; inval_valid = 1'b0;
    lookup(4'd3, 3'd6);
    touch(4'd3, 3'd6);
    lookup(4'd3, 3'd2);
    idle(2);

    // 5: backpressure holds the pending victim and blocks new lookups
    victim_ready = 1'b0;
    lookup(4'd3, 3'd2);
    lookup_valid = 1'b1; lookup_set = 4'd5;
    exp_q.push_back({4'd5, 3'd0});
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("hold_lookup_ready", int'(lookup_ready), 0);
      check("hold_victim_valid", int'(victim_valid), 1);
      check("hold_victim_set", int'(victim_set), 3);
      check("hold_victim_way", int'(victim_way), 2);
      @(posedge clk); #1;
    end
    victim_ready = 1'b1;
    @(negedge clk);
    check("release_lookup_ready", int'(lookup_ready), 1);
    @(posedge clk); #1;
    lookup_valid = 1'b0;
    @(negedge clk);
    check("accepted_victim_valid", int'(victim_valid), 1);
    check("accepted_victim_set", int'(victim_set), 5);
    @(posedge clk); #1;
    idle(2);

    // 6: async reset mid-cycle drops a pending victim and clears all state
    victim_ready = 1'b0;
    lookup(4'd3, 3'd2);
    check("pre_rst_victim_valid", int'(victim_valid), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_victim_valid", int'(victim_valid), 0);
    check("async_rst_victim_way", int'(victim_way), 0);
    void'(exp_q.pop_back());
    victim_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    lookup(4'd3, 3'd0);
    lookup(4'd9, 3'd0);
    idle(3);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
